mmio_console: RTL and testbench
===============================

MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h9000_0000, console window base; TXDATA at BASE_ADDR, EXIT at BASE_ADDR+4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, character FIFO entries; power of 2, minimum 2.
REQ-003 SHALL have port io_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port io_rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port io_pclken, input, 1, one-io_clk-cycle bit-rate enable pulse.
REQ-006 SHALL have port io_wvalid, input, 1, core store request.
REQ-007 SHALL have port io_waddr, input, 32, store byte address.
REQ-008 SHALL have port io_wdata, input, 32, store data.
REQ-009 SHALL have port io_wstrb, input, 4, store byte enables.
REQ-010 SHALL have port io_wready, output, 1, store accepted when high with io_wvalid.
REQ-011 SHALL have port io_txd, output, 1, 8N1 serial character output, idle high.
REQ-012 SHALL have port io_exit_valid, output, 1, sticky end-of-test flag.
REQ-013 SHALL have port io_exit_code, output, 32, end-of-test code.
REQ-014 SHALL have port io_char_cnt, output, 16, count of fully transmitted characters.
REQ-015 SHALL have port io_fifo_level, output, log2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-016 SHALL have port io_busy, output, 1, FIFO non-empty or transmitter not IDLE.

Function
REQ-017 io_wready SHALL be combinationally 0 only when io_waddr==BASE_ADDR and FIFO full; 1 otherwise.
REQ-018 Write handshake SHALL complete in the cycle io_wvalid && io_wready; no store is held or queued.
REQ-019 Accepted TXDATA write with io_wstrb[0]=1 SHALL push io_wdata[7:0]; io_wstrb[0]=0 SHALL complete without a push.
REQ-020 First accepted EXIT write SHALL set io_exit_valid=1 and io_exit_code=io_wdata on the next edge; later EXIT writes ignored until reset.
REQ-021 Accepted writes to other addresses SHALL complete with no effect.
REQ-022 Transmitter FSM states SHALL be IDLE, START, DATA, STOP; transitions only on io_pclken cycles.
REQ-023 IDLE: io_txd=1; on io_pclken with FIFO non-empty, pop head into shift register, io_txd<=0, go to START.
REQ-024 START: on io_pclken, io_txd<=bit0, bit index<=0, go to DATA.
REQ-025 DATA: on io_pclken, index 7 -> io_txd<=1, go to STOP; else index+1 and drive next bit, LSB first.
REQ-026 STOP: on io_pclken, io_char_cnt+1 (wrap 16'hFFFF->0); if FIFO non-empty pop and go to START with io_txd<=0, else go to IDLE.
REQ-027 Each character SHALL occupy exactly 10 io_pclken periods; back-to-back characters SHALL have no idle gap.
REQ-028 A push SHALL be visible to the FIFO pop logic no earlier than the cycle after acceptance.
REQ-029 Simultaneous push and pop SHALL leave io_fifo_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 A full FIFO SHALL NOT accept a same-cycle push against a pop; io_wready uses pre-pop full.
REQ-031 io_busy SHALL be registered-state derived: (state!=IDLE) || (io_fifo_level!=0).
REQ-032 Stores while io_exit_valid=1 SHALL still be processed per REQ-019/021.

Reset
REQ-033 io_rstn low SHALL immediately force: state IDLE, io_txd=1, FIFO empty, io_fifo_level=0, io_exit_valid=0, io_exit_code=0, io_char_cnt=0, io_busy=0.
REQ-034 Reset mid-character SHALL abort it, discard FIFO contents and not count it; io_wready=1 during reset.
REQ-035 After io_rstn deassertion, first pop SHALL occur on the first io_pclken with FIFO non-empty.

Verification
REQ-036 Write 0x0000_0041 to 0x9000_0000 strb 4'b0001, io_pclken every 10 cycles -> io_txd sequence 0,1,0,0,0,0,0,1,0,1 each 10 cycles; io_char_cnt=1.
REQ-037 Write 17 chars without pclken -> 16 accepted, 17th sees io_wready=0; io_fifo_level=16; first pclken -> level 15, pending write accepted next cycle.
REQ-038 Write 0x0000_0001 then 0x0000_0002 to 0x9000_0004 -> io_exit_valid=1, io_exit_code=1 held.
REQ-039 Write "ab\n" back-to-back -> 30 contiguous pclken bit periods, no idle bit; io_char_cnt=3; io_busy falls after last stop bit.
REQ-040 Assert io_rstn low during DATA bit 3 with 4 chars queued -> io_txd=1 immediately, level 0, io_char_cnt=0.
REQ-041 Write 0x41 to 0x9000_0000 strb 4'b0010, and to 0x9000_0008 -> both accepted, no push, io_txd stays 1.

Source files
------------

// File: rtl/mmio_console.sv
// Memory-mapped debug console: stores to TXDATA queue bytes for an 8N1 serial
// transmitter paced by io_pclken; a store to EXIT latches a sticky end-of-test code.
module mmio_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic                          io_clk,
    input  logic                          io_rstn,
    input  logic                          io_pclken,
    input  logic                          io_wvalid,
    input  logic [31:0]                   io_waddr,
    input  logic [31:0]                   io_wdata,
    input  logic [3:0]                    io_wstrb,
    output logic                          io_wready,
    output logic                          io_txd,
    output logic                          io_exit_valid,
    output logic [31:0]                   io_exit_code,
    output logic [15:0]                   io_char_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   io_fifo_level,
    output logic                          io_busy
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] EXIT_ADDR = BASE_ADDR + 32'd4;
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          txdata_hit;
    logic          exit_hit;
    logic          fifo_full;
    logic          fifo_empty;
    logic          wr_fire;
    logic          push;
    logic          pop;
    tx_state_t     state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic          unused_strb;

    assign unused_strb = &{1'b0, io_wstrb[3:1]};

    assign txdata_hit = (io_waddr == BASE_ADDR);
    assign exit_hit   = (io_waddr == EXIT_ADDR);
    assign fifo_full  = (io_fifo_level == FULL_LVL);
    assign fifo_empty = (io_fifo_level == '0);

    // Back-pressure uses the pre-pop level, so a full FIFO never takes a push
    // even in the cycle the transmitter frees an entry.
    assign io_wready = !(txdata_hit && fifo_full);
    assign wr_fire   = io_wvalid && io_wready;
    assign push      = wr_fire && txdata_hit && io_wstrb[0];
    assign pop       = io_pclken && !fifo_empty && (state == IDLE || state == STOP);

    assign io_busy = (state != IDLE) || !fifo_empty;

    // NOTE: character storage has no reset; emptiness is defined by the pointers
    // and level, so clearing the array would only add reset fan-out.
    always_ff @(posedge io_clk) begin
        if (push) begin
            mem[wr_ptr] <= io_wdata[7:0];
        end
    end

    // NOTE: non-blocking assignments throughout sequential logic, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge io_clk or negedge io_rstn) begin
        if (!io_rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            io_fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   io_fifo_level <= io_fifo_level + 1'b1;
                2'b01:   io_fifo_level <= io_fifo_level - 1'b1;
                default: io_fifo_level <= io_fifo_level;
            endcase
        end
    end

    always_ff @(posedge io_clk or negedge io_rstn) begin
        if (!io_rstn) begin
            io_exit_valid <= 1'b0;
            io_exit_code  <= '0;
        end else if (wr_fire && exit_hit && !io_exit_valid) begin
            io_exit_valid <= 1'b1;
            io_exit_code  <= io_wdata;
        end
    end

    always_ff @(posedge io_clk or negedge io_rstn) begin
        if (!io_rstn) begin
            state       <= IDLE;
            io_txd      <= 1'b1;
            shift       <= '0;
            bit_idx     <= '0;
            io_char_cnt <= '0;
        end else if (io_pclken) begin
            case (state)
                IDLE: begin
                    io_txd <= 1'b1;
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        io_txd <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    io_txd  <= shift[0];
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_idx == 3'd7) begin
                        io_txd <= 1'b1;
                        state  <= STOP;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        io_txd  <= shift[bit_idx + 3'd1];
                    end
                end
                STOP: begin
                    io_char_cnt <= io_char_cnt + 16'd1;
                    // Chain straight into the next start bit so characters abut.
                    if (pop) begin
                        shift  <= mem[rd_ptr];
                        io_txd <= 1'b0;
                        state  <= START;
                    end else begin
                        io_txd <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    io_txd <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Bench for mmio_console: a frame-position model of the console is compared with
// the DUT every cycle, plus literal expectations for the directed scenarios.
module tb_mmio_console;

    localparam logic [31:0] BASE  = 32'h9000_0000;
    localparam int          DEPTH = 16;

    logic        io_clk    = 1'b0;
    logic        io_rstn   = 1'b1;
    logic        io_pclken = 1'b0;
    logic        io_wvalid = 1'b0;
    logic [31:0] io_waddr  = '0;
    logic [31:0] io_wdata  = '0;
    logic [3:0]  io_wstrb  = '0;
    logic        io_wready;
    logic        io_txd;
    logic        io_exit_valid;
    logic [31:0] io_exit_code;
    logic [15:0] io_char_cnt;
    logic [4:0]  io_fifo_level;
    logic        io_busy;

    mmio_console #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .io_clk(io_clk), .io_rstn(io_rstn), .io_pclken(io_pclken),
        .io_wvalid(io_wvalid), .io_waddr(io_waddr), .io_wdata(io_wdata),
        .io_wstrb(io_wstrb), .io_wready(io_wready), .io_txd(io_txd),
        .io_exit_valid(io_exit_valid), .io_exit_code(io_exit_code),
        .io_char_cnt(io_char_cnt), .io_fifo_level(io_fifo_level), .io_busy(io_busy)
    );

    always #5 io_clk = ~io_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: a character is a 10-slot frame; m_pos is the slot on the line, -1 when idle.
    logic [7:0]  mq[$];
    int          m_pos       = -1;
    logic [7:0]  m_chr       = '0;
    logic [15:0] m_cnt       = '0;
    logic        m_exit_v    = 1'b0;
    logic [31:0] m_exit_code = '0;

    function automatic logic m_txd();
        if (m_pos < 0 || m_pos == 9) return 1'b1;
        if (m_pos == 0) return 1'b0;
        return m_chr[m_pos-1];
    endfunction

    function automatic logic m_wready();
        return !(io_waddr == BASE && mq.size() == DEPTH);
    endfunction

    always @(posedge io_clk or negedge io_rstn) begin
        if (!io_rstn) begin
            mq.delete();
            m_pos       = -1;
            m_cnt       = '0;
            m_exit_v    = 1'b0;
            m_exit_code = '0;
        end else begin
            bit acc;
            bit do_push;
            acc     = io_wvalid && m_wready();
            do_push = acc && io_waddr == BASE && io_wstrb[0];
            if (acc && io_waddr == BASE + 32'd4 && !m_exit_v) begin
                m_exit_v    = 1'b1;
                m_exit_code = io_wdata;
            end
            if (io_pclken) begin
                if (m_pos == 9) begin
                    m_cnt = m_cnt + 16'd1;
                    m_pos = -1;
                end else if (m_pos >= 0) begin
                    m_pos++;
                end
                if (m_pos == -1 && mq.size() != 0) begin
                    m_chr = mq.pop_front();
                    m_pos = 0;
                end
            end
            if (do_push) mq.push_back(io_wdata[7:0]);
        end
    end

    bit cmp_on = 1'b0;
    always @(negedge io_clk) begin
        if (cmp_on) begin
            check("txd",        io_txd,        m_txd());
            check("wready",     io_wready,     m_wready());
            check("fifo_level", io_fifo_level, mq.size());
            check("busy",       io_busy,       (m_pos != -1) || (mq.size() != 0));
            check("char_cnt",   io_char_cnt,   m_cnt);
            check("exit_valid", io_exit_valid, m_exit_v);
            check("exit_code",  io_exit_code,  m_exit_code);
        end
    end

    // Line log: io_txd after every pclken edge, i.e. one entry per bit period.
    bit   pclk_seen = 1'b0;
    logic txlog[$];
    always @(posedge io_clk) pclk_seen = io_pclken;
    always @(negedge io_clk) if (pclk_seen) txlog.push_back(io_txd);

    int cyc      = 0;
    int pclk_per = 0;
    bit pulse    = 1'b0;

    task automatic tick();
        @(posedge io_clk);
        #2;
        cyc++;
        io_pclken = pulse || (pclk_per != 0 && cyc % pclk_per == 0);
        pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit ok;
        io_wvalid = 1'b1;
        io_waddr  = addr;
        io_wdata  = data;
        io_wstrb  = strb;
        for (int i = 0; i < 200; i++) begin
            @(negedge io_clk);
            ok = io_wready;
            tick();
            if (ok) begin
                io_wvalid = 1'b0;
                return;
            end
        end
        io_wvalid = 1'b0;
        check("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge io_clk);
            if (!io_busy) begin
                tick();
                return;
            end
            tick();
        end
        check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        io_rstn = 1'b0;
        idle(3);
        io_rstn = 1'b1;
        tick();
    endtask

    function automatic int first_zero();
        for (int i = 0; i < txlog.size(); i++) if (txlog[i] == 1'b0) return i;
        return -1;
    endfunction

    bit exp36 [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    logic [7:0] str39 [3] = '{8'h61, 8'h62, 8'h0a};

    initial begin
        int z;
        bit got;
        #1 io_rstn = 1'b0;
        cmp_on = 1'b1;
        io_waddr = BASE;
        @(negedge io_clk);
        check("rst_txd", io_txd, 1);
        check("rst_level", io_fifo_level, 0);
        check("rst_busy", io_busy, 0);
        check("rst_exit", io_exit_valid, 0);
        check("rst_cnt", io_char_cnt, 0);
        check("rst_wready", io_wready, 1);
        idle(2);
        io_rstn = 1'b1;
        tick();

        // Single 'A' at one bit per 10 cycles.
        pclk_per = 10;
        txlog.delete();
        do_write(BASE, 32'h0000_0041, 4'b0001);
        wait_idle(400);
        idle(12);
        z = first_zero();
        check("a_log_len", (z >= 0 && txlog.size() >= z + 10), 1);
        if (z >= 0 && txlog.size() >= z + 10)
            for (int i = 0; i < 10; i++) check($sformatf("a_bit%0d", i), txlog[z+i], exp36[i]);
        check("a_cnt", io_char_cnt, 1);

        // Fill to full with the line stalled, then release one entry.
        pclk_per = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_write(BASE, 32'h30 + i, 4'b0001);
        @(negedge io_clk);
        check("full_level", io_fifo_level, 16);
        tick();
        io_wvalid = 1'b1; io_waddr = BASE; io_wdata = 32'h55; io_wstrb = 4'b0001;
        @(negedge io_clk);
        check("full_wready", io_wready, 0);
        pulse = 1'b1;
        tick();
        @(negedge io_clk);
        check("full_wready_pclk", io_wready, 0);
        tick();
        @(negedge io_clk);
        check("pop_level", io_fifo_level, 15);
        check("pop_wready", io_wready, 1);
        tick();
        io_wvalid = 1'b0;
        @(negedge io_clk);
        check("refill_level", io_fifo_level, 16);
        pclk_per = 2;
        wait_idle(2000);

        // First EXIT wins.
        do_write(BASE + 32'd4, 32'h1, 4'hf);
        do_write(BASE + 32'd4, 32'h2, 4'hf);
        idle(2);
        check("exit_valid", io_exit_valid, 1);
        check("exit_code", io_exit_code, 1);

        // Stores that complete without a push.
        do_write(BASE, 32'h41, 4'b0010);
        do_write(BASE + 32'd8, 32'h41, 4'b0001);
        idle(4);
        check("nopush_level", io_fifo_level, 0);
        check("nopush_txd", io_txd, 1);

        // "ab\n" back to back: 30 abutting bit periods.
        do_reset();
        pclk_per = 4;
        txlog.delete();
        for (int i = 0; i < 3; i++) do_write(BASE, {24'h0, str39[i]}, 4'b0001);
        wait_idle(1000);
        idle(6);
        check("ab_cnt", io_char_cnt, 3);
        z = first_zero();
        check("ab_log_len", (z >= 0 && txlog.size() >= z + 30), 1);
        if (z >= 0 && txlog.size() >= z + 30)
            for (int c = 0; c < 3; c++)
                for (int b = 0; b < 10; b++)
                    check($sformatf("ab_c%0d_b%0d", c, b), txlog[z + c*10 + b],
                          (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : str39[c][b-1]);

        // Reset during data bit 3 with characters queued.
        do_reset();
        txlog.delete();
        for (int i = 0; i < 4; i++) do_write(BASE, 32'h0, 4'b0001);
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge io_clk);
            #1;
            z = first_zero();
            if (z >= 0 && txlog.size() >= z + 5) got = 1'b1;
            else tick();
        end
        check("mid_reached", got, 1);
        check("mid_txd_before", io_txd, 0);
        io_rstn = 1'b0;
        #1;
        check("mid_txd", io_txd, 1);
        check("mid_level", io_fifo_level, 0);
        check("mid_cnt", io_char_cnt, 0);
        check("mid_busy", io_busy, 0);
        idle(2);
        io_rstn = 1'b1;
        tick();

        // Random traffic against the model.
        for (int it = 0; it < 300; it++) begin
            int r;
            if (it % 50 == 0) pclk_per = $urandom_range(1, 5);
            if (it == 150) do_reset();
            r = $urandom_range(0, 9);
            if (r < 6)       do_write(BASE, $urandom, 4'($urandom_range(0, 15)));
            else if (r == 6) do_write(BASE + 32'd4, $urandom, 4'hf);
            else if (r == 7) do_write(($urandom_range(0, 1) != 0) ? BASE + 32'd8 : BASE + 32'd1, $urandom, 4'hf);
            else             idle($urandom_range(1, 5));
        end
        wait_idle(4000);
        idle(4);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
